// File: rtl/cnn_conv_ctrl_pkg.sv
// rtl/cnn_conv_ctrl_pkg.sv - shared window geometry, packing index and sequencer state encoding
package cnn_conv_ctrl_pkg;

    localparam int KW = 3;
    localparam int KH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Row 0 / column 0 is the oldest (top-left) pixel of the window.
    function automatic int win_idx(input int r, input int c);
        return r * KW + c;
    endfunction

endpackage

// File: rtl/cnn_conv_ctrl_if.sv
// rtl/cnn_conv_ctrl_if.sv - pixel stream, weight load and kernel handshake bundle for cnn_conv_ctrl
interface cnn_conv_ctrl_if #(
    parameter int IF_BW = 8,
    parameter int W_BW  = 8,
    parameter int KN    = 9
);
    logic                  i_start;
    logic                  i_w_load;
    logic [KN*W_BW-1:0]    i_w_data;
    logic                  i_pix_valid;
    logic [IF_BW-1:0]      i_pix_data;
    logic                  o_pix_ready;
    logic                  o_k_valid;
    logic [KN*IF_BW-1:0]   o_k_fmap;
    logic [KN*W_BW-1:0]    o_k_weight;
    logic                  i_k_valid;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_w_load, i_w_data, i_pix_valid, i_pix_data, i_k_valid,
        output o_pix_ready, o_k_valid, o_k_fmap, o_k_weight, o_busy, o_done
    );

    modport master (
        output i_start, i_w_load, i_w_data, i_pix_valid, i_pix_data, i_k_valid,
        input  o_pix_ready, o_k_valid, o_k_fmap, o_k_weight, o_busy, o_done
    );
endinterface

// File: rtl/cnn_line_buffer.sv
// rtl/cnn_line_buffer.sv - single-port row buffer, combinational read of the old word then write
module cnn_line_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
endmodule

// File: rtl/cnn_conv_ctrl.sv
// rtl/cnn_conv_ctrl.sv - builds 3x3 valid-convolution windows from a raster pixel stream for cnn_kernel
module cnn_conv_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int IF_BW = 8,
    parameter int W_BW  = 8,
    parameter int KW    = cnn_conv_ctrl_pkg::KW,
    parameter int KH    = cnn_conv_ctrl_pkg::KH
) (
    input  logic             clk,
    input  logic             rst,
    cnn_conv_ctrl_if.slave   bus
);
    import cnn_conv_ctrl_pkg::*;

    localparam int N_OUT = (IMG_H - 2) * (IMG_W - 2);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NW    = $clog2(N_OUT + 1);
    localparam int FW    = KW * KH * IF_BW;
    localparam int WW    = KW * KH * W_BW;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [NW-1:0] CNT_MAX  = NW'(N_OUT);

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [NW-1:0]   r_cnt;
    logic [FW-1:0]   r_win;
    logic [FW-1:0]   r_fmap;
    logic [WW-1:0]   r_weight;
    logic            r_k_valid;
    logic            r_done;

    logic            w_accept;
    logic            w_issue;
    logic            w_last_pix;
    logic            w_cnt_inc;
    logic [NW-1:0]   w_cnt_nxt;
    logic [IF_BW-1:0] w_lb0_rd;
    logic [IF_BW-1:0] w_lb1_rd;
    logic [FW-1:0]   w_win_nxt;

    assign w_accept   = bus.i_pix_valid && (r_state == ST_STREAM);
    assign w_issue    = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_pix = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_cnt_inc  = bus.i_k_valid && (r_state != ST_IDLE) && (r_cnt != CNT_MAX);
    assign w_cnt_nxt  = r_cnt + NW'(w_cnt_inc);

    // lb0 holds the row two above the incoming pixel, lb1 the row directly above.
    cnn_line_buffer #(.DEPTH(IMG_W), .DW(IF_BW)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb0_rd)
    );

    cnn_line_buffer #(.DEPTH(IMG_W), .DW(IF_BW)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (bus.i_pix_data),
        .o_rdata (w_lb1_rd)
    );

    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < KH; r++) begin
            for (int c = 0; c < KW - 1; c++) begin
                w_win_nxt[win_idx(r, c)*IF_BW +: IF_BW] = r_win[win_idx(r, c + 1)*IF_BW +: IF_BW];
            end
        end
        w_win_nxt[win_idx(0, KW - 1)*IF_BW +: IF_BW] = w_lb0_rd;
        w_win_nxt[win_idx(1, KW - 1)*IF_BW +: IF_BW] = w_lb1_rd;
        w_win_nxt[win_idx(2, KW - 1)*IF_BW +: IF_BW] = bus.i_pix_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_cnt     <= '0;
            r_win     <= '0;
            r_fmap    <= '0;
            r_weight  <= '0;
            r_k_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_k_valid <= 1'b0;
            r_done    <= 1'b0;

            if (w_cnt_inc) begin
                r_cnt <= w_cnt_nxt;
            end

            if (w_accept) begin
                r_win <= w_win_nxt;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_issue) begin
                    r_k_valid <= 1'b1;
                    r_fmap    <= w_win_nxt;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_w_load) begin
                        r_weight <= bus.i_w_data;
                    end
                    if (bus.i_start) begin
                        r_state <= ST_STREAM;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_last_pix) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_nxt == CNT_MAX) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_pix_ready = (r_state == ST_STREAM);
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_k_valid   = r_k_valid;
    assign bus.o_k_fmap    = r_fmap;
    assign bus.o_k_weight  = r_weight;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// tb/tb_cnn_conv_ctrl.sv - directed self-checking bench for cnn_conv_ctrl on a 5x5 frame
module tb_cnn_conv_ctrl;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int IF_BW = 8;
    localparam int W_BW  = 8;
    localparam int KN    = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_conv_ctrl_if #(.IF_BW(IF_BW), .W_BW(W_BW), .KN(KN)) bus ();

    cnn_conv_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IF_BW(IF_BW), .W_BW(W_BW), .KW(3), .KH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n, dones, kv_cnt, kv9, done_cyc, late;
    logic [1:0] kpipe;
    logic kstray;
    int res[$];
    logic [71:0] fm[$];
    logic [71:0] wts;

    int exp_ones[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    logic [71:0] first_win = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dot(input logic [71:0] f, input logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++) begin
            int a = f[k*8 +: 8];
            int b = w[k*8 +: 8];
            s += a * b;
        end
        return s;
    endfunction

    // One clock: drive inputs, edge, sample 1 time unit later; also acts as a 2-cycle kernel.
    task automatic cyc(input logic pv, input logic [7:0] pd);
        logic acc;
        bus.i_pix_valid = pv;
        bus.i_pix_data  = pd;
        bus.i_k_valid   = kpipe[1] | kstray;
        acc = pv & bus.o_pix_ready;
        if (bus.i_k_valid) begin
            kv_cnt++;
            if (kv_cnt == 9) kv9 = cyc_n;
        end
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        bus.i_w_load = 1'b0;
        kpipe = {kpipe[0], bus.o_k_valid};
        if (bus.o_k_valid) begin
            fm.push_back(bus.o_k_fmap);
            res.push_back(dot(bus.o_k_fmap, bus.o_k_weight));
            if (!acc) late++;
        end
        if (bus.o_done) begin
            dones++;
            done_cyc = cyc_n;
        end
        cyc_n++;
    endtask

    task automatic load_w(input logic [71:0] w);
        bus.i_w_load = 1'b1;
        bus.i_w_data = w;
        cyc(1'b0, 8'd0);
    endtask

    task automatic run_frame(input int base, input bit gaps, input int stray_start,
                             input int stray_wl, input bit extra_kv, input int tail);
        fm.delete();
        res.delete();
        dones = 0; late = 0; kv_cnt = 0; kv9 = -1; done_cyc = -2;
        kpipe = 2'b00; kstray = 1'b0;
        bus.i_start = 1'b1;
        cyc(1'b0, 8'd0);
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            if (gaps) cyc(1'b0, 8'hEE);
            if (i == stray_start) bus.i_start = 1'b1;
            if (i == stray_wl) begin
                bus.i_w_load = 1'b1;
                bus.i_w_data = {9{8'hAA}};
            end
            cyc(1'b1, 8'(base + i + 1));
        end
        for (int t = 0; t < 40 && dones == 0; t++) begin
            kstray = extra_kv;
            cyc(1'b0, 8'd0);
        end
        for (int t = 0; t < tail; t++) begin
            kstray = extra_kv;
            cyc(1'b0, 8'd0);
        end
        kstray = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_beats"}, fm.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_res%0d", tag, i), (res.size() > i) ? res[i] : -1, exp_ones[i]);
        end
        chk({tag, "_win0"}, (fm.size() > 0) ? fm[0] : 72'd0, first_win);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_idle"}, bus.o_busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_kvalid"}, bus.o_k_valid, 1'b0);
        chk({tag, "_fmap"}, bus.o_k_fmap, 72'd0);
        chk({tag, "_weight"}, bus.o_k_weight, 72'd0);
        chk({tag, "_busy"}, bus.o_busy, 1'b0);
        chk({tag, "_ready"}, bus.o_pix_ready, 1'b0);
        chk({tag, "_done"}, bus.o_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_w_load = 1'b0; bus.i_w_data = '0;
        bus.i_pix_valid = 1'b0; bus.i_pix_data = '0; bus.i_k_valid = 1'b0;
        kpipe = 2'b00; kstray = 1'b0; cyc_n = 0;
        dones = 0; late = 0; kv_cnt = 0; kv9 = -1; done_cyc = -2;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, unit weights
        load_w({9{8'd1}});
        chk("w_ones", bus.o_k_weight, {9{8'd1}});
        run_frame(0, 1'b0, -1, -1, 1'b0, 4);
        check_frame("basic");
        chk("basic_done_timing", done_cyc, kv9);

        // Pixel gaps every other cycle
        run_frame(0, 1'b1, -1, -1, 1'b0, 4);
        check_frame("gaps");
        chk("gaps_latency", late, 0);

        // Descending weights, plus a load attempt mid-stream
        for (int k = 0; k < 9; k++) wts[k*8 +: 8] = 8'(9 - k);
        load_w(wts);
        chk("w_desc", bus.o_k_weight, wts);
        run_frame(0, 1'b0, -1, 5, 1'b0, 4);
        chk("w_desc_kept", bus.o_k_weight, wts);
        chk("w_desc_beats", fm.size(), 9);
        chk("w_desc_first", (res.size() > 0) ? res[0] : -1, 219);
        chk("w_desc_last", (res.size() > 8) ? res[8] : -1, 759);

        // Stray start during stream and surplus kernel returns in drain
        load_w({9{8'd1}});
        run_frame(0, 1'b0, 7, -1, 1'b1, 6);
        check_frame("stray");

        // Reset in the middle of a frame
        bus.i_start = 1'b1;
        cyc(1'b0, 8'd0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(i + 1));
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        load_w({9{8'd1}});
        run_frame(0, 1'b0, -1, -1, 1'b0, 4);
        check_frame("after_rst");

        // Back-to-back frames, first one with distinct pixel values
        run_frame(100, 1'b0, -1, -1, 1'b0, 0);
        chk("b2b_f1_beats", fm.size(), 9);
        chk("b2b_f1_done", dones, 1);
        run_frame(0, 1'b0, -1, -1, 1'b0, 4);
        check_frame("b2b_f2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
